// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: command codes, frame geometry,
// master FSM state encoding and the host request frame layout.
package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE, START, CMD, SHIFT, HOLD, WAIT, RECV, END
    } spi_state_t;

    typedef struct packed {
        logic [1:0]        cmd;
        logic [DATA_W-1:0] data;
    } spi_frame_t;

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath for the SPI master.
//   load/load_word : parallel load of the outgoing 10-bit frame
//   shift_en       : advance the outgoing frame by one bit (MSB first)
//   tx_bit         : current outgoing MSB
//   sample_en/miso : shift one MISO bit into the capture register
//   rx_next        : capture register value including the current MISO bit
//   cnt_clr/cnt    : shared bit counter, cleared on clr, else increments
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_word,
    input  logic               shift_en,
    input  logic               sample_en,
    input  logic               miso,
    input  logic               cnt_clr,
    output logic               tx_bit,
    output logic [3:0]         cnt,
    output logic [DATA_W-1:0]  rx_next
);

    logic [FRAME_W-1:0] tx_sh;
    logic [DATA_W-1:0]  rx_sh;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_sh <= '0;
            rx_sh <= '0;
            cnt   <= '0;
        end else begin
            if (load)
                tx_sh <= load_word;
            else if (shift_en)
                tx_sh <= {tx_sh[FRAME_W-2:0], 1'b0};
            if (sample_en)
                rx_sh <= rx_next;
            cnt <= cnt_clr ? 4'd0 : cnt + 4'd1;
        end
    end

    assign tx_bit  = tx_sh[FRAME_W-1];
    assign rx_next = {rx_sh[DATA_W-2:0], miso};

endmodule

// File: rtl/spi_master_ctrl.sv
// Host-side SPI master sharing clk with the slave (no SCK).
// Accepts {req_cmd, req_data} on a valid/ready handshake, sends it as a
// 10-bit frame MSB first on MOSI with SS_n low, and for rd-data commands
// captures an 8-bit MISO reply returned on rsp_valid/rsp_data.
//   clk, rst_n                   : clock, synchronous active-low reset
//   req_valid/req_ready          : command handshake
//   req_cmd, req_data            : command code and payload
//   rsp_valid, rsp_data          : rd-data reply strobe and byte
//   busy                         : accept through end of the inter-frame gap
//   SS_n, MOSI, MISO             : serial interface
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int RD_WAIT = 4,
    parameter int GAP     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_cmd,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

    spi_state_t        state, state_d;
    spi_frame_t        req_frame;
    logic              accept;
    logic              is_rd;
    logic              tx_bit;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] rx_next;

    assign req_frame = '{cmd: req_cmd, data: req_data};
    assign accept    = (state == IDLE) && req_ready && req_valid;

    spi_master_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_word (req_frame),
        .shift_en  (state_d == SHIFT),
        .sample_en (state == RECV),
        .miso      (MISO),
        .cnt_clr   (state_d != state),
        .tx_bit    (tx_bit),
        .cnt       (cnt),
        .rx_next   (rx_next)
    );

    // The counter is cleared on every state change, so each timed state
    // sees cnt start at 0 on its first cycle.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = START;
            START:   state_d = CMD;
            CMD:     state_d = SHIFT;
            SHIFT:   if (cnt == 4'd9) state_d = is_rd ? WAIT : HOLD;
            HOLD:    state_d = END;
            WAIT:    if (cnt == WAIT_LAST) state_d = RECV;
            RECV:    if (cnt == 4'd7) state_d = END;
            END:     if (cnt == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe. MOSI takes the pre-shift MSB, so frame[9] appears
    // in both CMD and the first SHIFT cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            is_rd     <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_d;
            SS_n      <= (state_d == IDLE) || (state_d == END);
            MOSI      <= ((state_d == CMD) || (state_d == SHIFT)) ? tx_bit : 1'b0;
            req_ready <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            rsp_valid <= (state == RECV) && (state_d == END);
            if ((state == RECV) && (state_d == END))
                rsp_data <= rx_next;
            if (accept)
                is_rd <= (req_cmd == CMD_RD_DATA);
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_req_valid, a_req_ready, a_rsp_valid, a_busy, a_ss_n, a_mosi, a_miso;
    logic [1:0] a_req_cmd;
    logic [7:0] a_req_data, a_rsp_data;
    logic       b_req_valid, b_req_ready, b_rsp_valid, b_busy, b_ss_n, b_mosi, b_miso;
    logic [1:0] b_req_cmd;
    logic [7:0] b_req_data, b_rsp_data;

    spi_master_ctrl #(.RD_WAIT(4), .GAP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_cmd(a_req_cmd), .req_data(a_req_data), .rsp_valid(a_rsp_valid),
        .rsp_data(a_rsp_data), .busy(a_busy), .SS_n(a_ss_n), .MOSI(a_mosi), .MISO(a_miso));

    spi_master_ctrl #(.RD_WAIT(2), .GAP(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_cmd(b_req_cmd), .req_data(b_req_data), .rsp_valid(b_rsp_valid),
        .rsp_data(b_rsp_data), .busy(b_busy), .SS_n(b_ss_n), .MOSI(b_mosi), .MISO(b_miso));

    int checks = 0;
    int failures = 0;

    logic       ss_l [0:63];
    logic       mosi_l [0:63];
    logic       rv_l [0:63];
    logic       rdy_l [0:63];
    logic       busy_l [0:63];
    logic [7:0] rd_l [0:63];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? b_req_ready : a_req_ready;
    endfunction

    task automatic log_at(input bit sel, input int k);
        ss_l[k]   = sel ? b_ss_n      : a_ss_n;
        mosi_l[k] = sel ? b_mosi      : a_mosi;
        rv_l[k]   = sel ? b_rsp_valid : a_rsp_valid;
        rdy_l[k]  = sel ? b_req_ready : a_req_ready;
        busy_l[k] = sel ? b_busy      : a_busy;
        rd_l[k]   = sel ? b_rsp_data  : a_rsp_data;
    endtask

    task automatic set_miso(input bit sel, input logic v);
        if (sel) b_miso = v; else a_miso = v;
    endtask

    function automatic int ss_low(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (ss_l[i] === 1'b0) n++;
        return n;
    endfunction

    function automatic int rv_cnt(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (rv_l[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic logic [9:0] mosi_word(input int s);
        logic [9:0] w;
        for (int i = 0; i < 10; i++) w[9-i] = mosi_l[s+i];
        return w;
    endfunction

    // Called at a negedge. Waits for ready, lets the next posedge accept,
    // then logs cycles C1..Cn (sampled at negedges), driving MISO bits
    // MSB first during cycles mstart..mstart+7.
    task automatic send(input bit sel, input logic [1:0] cmd, input logic [7:0] data,
                        input logic [7:0] mbyte, input int mstart, input int n);
        int t = 0;
        if (sel) begin b_req_valid = 1; b_req_cmd = cmd; b_req_data = data; end
        else     begin a_req_valid = 1; a_req_cmd = cmd; a_req_data = data; end
        while (!rdy(sel) && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) chk("accept_timeout", 32'(t), 32'd0);
        @(negedge clk);
        if (sel) begin b_req_valid = 0; b_req_cmd = 2'b00; b_req_data = 8'h00; end
        else     begin a_req_valid = 0; a_req_cmd = 2'b00; a_req_data = 8'h00; end
        for (int k = 1; k <= n; k++) begin
            log_at(sel, k);
            if (k >= mstart && k < mstart + 8) set_miso(sel, mbyte[7-(k-mstart)]);
            else set_miso(sel, 1'b0);
            if (k < n) @(negedge clk);
        end
        set_miso(sel, 1'b0);
    endtask

    initial begin
        int t;
        rst_n = 0;
        a_req_valid = 0; a_req_cmd = 0; a_req_data = 0; a_miso = 0;
        b_req_valid = 0; b_req_cmd = 0; b_req_data = 0; b_miso = 0;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_ss_n", 32'(a_ss_n), 1);
        chk("rst_mosi", 32'(a_mosi), 0);
        chk("rst_ready", 32'(a_req_ready), 0);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_rsp_data", 32'(a_rsp_data), 0);
        rst_n = 1;
        @(negedge clk);
        chk("rst_ready_after", 32'(a_req_ready), 1);

        // wr-addr 0xA5: frame 00_1010_0101
        send(0, 2'b00, 8'hA5, 8'h00, 99, 16);
        chk("wa_ss_low_cnt", 32'(ss_low(1, 16)), 13);
        chk("wa_ss_c1", 32'(ss_l[1]), 0);
        chk("wa_ss_c13", 32'(ss_l[13]), 0);
        chk("wa_ss_c14", 32'(ss_l[14]), 1);
        chk("wa_mosi_c1", 32'(mosi_l[1]), 0);
        chk("wa_mosi_c2", 32'(mosi_l[2]), 0);
        chk("wa_mosi_word", 32'(mosi_word(3)), 32'h0A5);
        chk("wa_mosi_c13", 32'(mosi_l[13]), 0);
        chk("wa_no_rsp", 32'(rv_cnt(1, 16)), 0);
        chk("wa_busy_c14", 32'(busy_l[14]), 1);
        chk("wa_ready_c14", 32'(rdy_l[14]), 0);
        chk("wa_ready_c15", 32'(rdy_l[15]), 1);
        chk("wa_busy_c15", 32'(busy_l[15]), 0);

        // rd-data, MISO 0x3C during C17..C24: frame 11_0011_1100
        send(0, 2'b11, 8'h3C, 8'h3C, 17, 27);
        chk("rd_mosi_c2", 32'(mosi_l[2]), 1);
        chk("rd_mosi_word", 32'(mosi_word(3)), 32'h33C);
        chk("rd_ss_low_cnt", 32'(ss_low(1, 27)), 24);
        chk("rd_ss_c24", 32'(ss_l[24]), 0);
        chk("rd_ss_c25", 32'(ss_l[25]), 1);
        chk("rd_rsp_cnt", 32'(rv_cnt(1, 27)), 1);
        chk("rd_rsp_c25", 32'(rv_l[25]), 1);
        chk("rd_rsp_data", 32'(rd_l[25]), 32'h3C);
        chk("rd_mosi_quiet", 32'({mosi_l[13], mosi_l[16], mosi_l[20], mosi_l[24]}), 0);
        chk("rd_ready_c26", 32'(rdy_l[26]), 1);

        // Back-to-back: wr-data 0xFF then rd-addr 0x10 with req_valid held
        a_req_valid = 1; a_req_cmd = 2'b01; a_req_data = 8'hFF;
        t = 0;
        while (!a_req_ready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) chk("b2b_timeout", 32'(t), 32'd0);
        @(negedge clk);
        a_req_cmd = 2'b10; a_req_data = 8'h10;
        for (int k = 1; k <= 30; k++) begin
            log_at(0, k);
            if (k == 16) a_req_valid = 0;
            if (k < 30) @(negedge clk);
        end
        chk("b2b_ss_low1", 32'(ss_low(1, 15)), 13);
        chk("b2b_ss_gap", 32'({ss_l[14], ss_l[15], ss_l[16]}), 32'b110);
        chk("b2b_ready_c14", 32'(rdy_l[14]), 0);
        chk("b2b_ready_c15", 32'(rdy_l[15]), 1);
        chk("b2b_ready_c16", 32'(rdy_l[16]), 0);
        chk("b2b_word1", 32'(mosi_word(3)), 32'h1FF);
        chk("b2b_word2", 32'(mosi_word(18)), 32'h210);
        chk("b2b_ss_low2", 32'(ss_low(16, 30)), 13);
        chk("b2b_no_rsp", 32'(rv_cnt(1, 30)), 0);
        chk("b2b_rsp_hold", 32'(a_rsp_data), 32'h3C);

        // Reset at C8 of an rd-data frame
        send(0, 2'b11, 8'h55, 8'hFF, 17, 8);
        chk("mid_ss_c8", 32'(ss_l[8]), 0);
        rst_n = 0;
        @(negedge clk);
        chk("mid_ss_after", 32'(a_ss_n), 1);
        chk("mid_rsp_valid", 32'(a_rsp_valid), 0);
        chk("mid_busy", 32'(a_busy), 0);
        rst_n = 1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            log_at(0, k);
        end
        chk("mid_no_rsp", 32'(rv_cnt(1, 30)), 0);
        chk("mid_ss_idle", 32'(ss_low(1, 30)), 0);
        send(0, 2'b11, 8'h5A, 8'h5A, 17, 27);
        chk("post_rsp_c25", 32'(rv_l[25]), 1);
        chk("post_rsp_data", 32'(rd_l[25]), 32'h5A);
        chk("post_ss_low", 32'(ss_low(1, 27)), 24);

        // RD_WAIT=2, GAP=3 build, MISO 0x81 during C15..C22
        send(1, 2'b11, 8'h81, 8'h81, 15, 27);
        chk("b_mosi_word", 32'(mosi_word(3)), 32'h381);
        chk("b_ss_low_cnt", 32'(ss_low(1, 27)), 22);
        chk("b_ss_c22", 32'(ss_l[22]), 0);
        chk("b_ss_gap", 32'({ss_l[23], ss_l[24], ss_l[25]}), 32'b111);
        chk("b_rsp_c23", 32'(rv_l[23]), 1);
        chk("b_rsp_cnt", 32'(rv_cnt(1, 27)), 1);
        chk("b_rsp_data", 32'(rd_l[23]), 32'h81);
        chk("b_ready_c25", 32'(rdy_l[25]), 0);
        chk("b_busy_c25", 32'(busy_l[25]), 1);
        chk("b_ready_c26", 32'(rdy_l[26]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
